// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, word type, responder FSM states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ramfsm_t;

    localparam int RAM_LAT_MAX = 15;

    function automatic logic [3:0] ram_lat_load(input int lat);
        return 4'(lat - 1);
    endfunction
endpackage

// File: rtl/ram_array.sv
// Single-port word array: combinational read, synchronous write enable, no reset.
module ram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX         = $clog2(DEPTH_WORDS)
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [IDX-1:0]    i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/ram_responder.sv
// RAM-side responder with programmable latency over a ram_array backing store.
// Optional RAM_ERROR_CHECK_EN: report ERROR on REN&WEN or out-of-range address.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);
    localparam int         IDX      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = ram_lat_load(LAT);

    ramfsm_t          r_state, w_state_n;
    logic [3:0]       r_cnt, w_cnt_n;
    logic             r_op, w_op_n;
    logic [IDX-1:0]   r_idx, w_idx_n;
    logic             r_committed, w_committed_n;

    logic             w_active, w_op, w_match, w_err, w_access, w_we, w_unused_addr;
    logic [IDX-1:0]   w_idx, w_arr_idx;
    word_t            w_rdata;

    assign w_active = ramREN | ramWEN;
    assign w_op     = ramWEN;
    assign w_idx    = ramaddr[IDX+1:2];
    assign w_match  = (w_op == r_op) && (w_idx == r_idx);

`ifdef RAM_ERROR_CHECK_EN
    assign w_err         = (ramREN & ramWEN) | (|(ramaddr >> (IDX + 2)));
    assign w_unused_addr = ^ramaddr[1:0];
`else
    assign w_err         = 1'b0;
    assign w_unused_addr = ^{ramaddr[1:0], ramaddr >> (IDX + 2)};
`endif

    // ACCESS begins on the last WAIT cycle (counter drained) so LAT=1 is legal.
    assign w_access = nRST & w_active & ~w_err & w_match &
                      ((r_state == DONE) || (r_state == WAIT && r_cnt == 4'd0));
    assign w_we     = w_access & r_op & ~r_committed;

    always_comb begin
        if (!w_active)     ramstate = FREE;
        else if (!nRST)    ramstate = BUSY;
        else if (w_err)    ramstate = ERROR;
        else if (w_access) ramstate = ACCESS;
        else               ramstate = BUSY;
    end

    assign ramload   = (ramstate == ACCESS && !r_op) ? w_rdata : '0;
    assign w_arr_idx = r_idx;

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_op_n        = r_op;
        w_idx_n       = r_idx;
        w_committed_n = r_committed | w_we;
        case (r_state)
            IDLE: begin
                if (w_active && !w_err) begin
                    w_state_n     = WAIT;
                    w_op_n        = w_op;
                    w_idx_n       = w_idx;
                    w_cnt_n       = LAT_LOAD;
                    w_committed_n = 1'b0;
                end
            end
            WAIT: begin
                if (!w_active || w_err) begin
                    w_state_n     = IDLE;
                    w_committed_n = 1'b0;
                end else if (!w_match) begin
                    w_op_n        = w_op;
                    w_idx_n       = w_idx;
                    w_cnt_n       = LAT_LOAD;
                    w_committed_n = 1'b0;
                end else if (r_cnt == 4'd0) begin
                    w_state_n = DONE;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            DONE: begin
                if (!w_active || w_err) begin
                    w_state_n     = IDLE;
                    w_committed_n = 1'b0;
                end else if (!w_match) begin
                    w_state_n     = WAIT;
                    w_op_n        = w_op;
                    w_idx_n       = w_idx;
                    w_cnt_n       = LAT_LOAD;
                    w_committed_n = 1'b0;
                end
            end
            default: begin
                w_state_n     = IDLE;
                w_committed_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 1'b0;
            r_idx       <= '0;
            r_committed <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_op        <= w_op_n;
            r_idx       <= w_idx_n;
            r_committed <= w_committed_n;
        end
    end

    ram_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX(IDX)) u_array (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_idx   (w_arr_idx),
        .i_wdata (ramstore),
        .o_rdata (w_rdata)
    );
endmodule
